// File: rtl/prog_ctr_seq_if.sv
// Harness-side bus of the program-counter stage: run control, decoded instruction
// fields in, instruction address and run status out.
interface prog_ctr_seq_if #(
    parameter int D  = 12,
    parameter int CW = 16
);
    logic                 Start;
    logic [D-1:0]         StartAddr;
    logic                 Stall;
    logic                 Halt;
    logic                 BranchEn;
    logic                 BranchFlag;
    logic signed [D-1:0]  Target;
    logic [D-1:0]         ProgCtr;
    logic                 Running;
    logic                 Done;
    logic [CW-1:0]        CycleCount;

    modport master (
        output Start, StartAddr, Stall, Halt, BranchEn, BranchFlag, Target,
        input  ProgCtr, Running, Done, CycleCount
    );

    modport slave (
        input  Start, StartAddr, Stall, Halt, BranchEn, BranchFlag, Target,
        output ProgCtr, Running, Done, CycleCount
    );
endinterface

// File: rtl/prog_ctr_seq.sv
// Program counter with IDLE/RUN/DONE run control and signed relative branches.
// Optional saturating RUN-cycle counter enabled by defining PC_CYCLE_COUNT_EN.
module prog_ctr_seq #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    prog_ctr_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [D-1:0]         pc_q, pc_d;
    logic [D-1:0]         pc_inc, pc_br;
    logic signed [D-1:0]  tgt;
    logic                 start_acc;

    // Same-width add wraps modulo 2^D, so the signed offset needs no extension.
    assign tgt    = bus.Target;
    assign pc_inc = pc_q + D'(1);
    assign pc_br  = pc_q + $unsigned(tgt);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    start_acc = 1'b1;
                    pc_d      = bus.StartAddr;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (bus.Stall) begin
                    pc_d = pc_q;
                end else if (bus.Halt) begin
                    state_d = DONE;
                end else if (bus.BranchEn && bus.BranchFlag) begin
                    pc_d = pc_br;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.ProgCtr = pc_q;
    assign bus.Running = (state_q == RUN);
    assign bus.Done    = (state_q == DONE);

`ifdef PC_CYCLE_COUNT_EN
    logic [CW-1:0] cnt_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Counts every RUN cycle, including stalls and the halt cycle itself.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign bus.CycleCount = cnt_q;
`else
    assign bus.CycleCount = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Randomized bench for prog_ctr_seq against a behavioural program-counter model,
// preceded by directed address/branch/stall/halt/reset scenarios.
module tb_prog_ctr_seq;
    localparam int D    = 12;
    localparam int CW   = 5;
    localparam int MODV = 1 << D;
    localparam int CMAX = (1 << CW) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    prog_ctr_seq_if #(.D(D), .CW(CW)) bus ();
    prog_ctr_seq #(.D(D), .CW(CW)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int errs   = 0;
    int checks = 0;
    int m_st, m_pc, m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.Start      = 1'b0;
        bus.StartAddr  = '0;
        bus.Stall      = 1'b0;
        bus.Halt       = 1'b0;
        bus.BranchEn   = 1'b0;
        bus.BranchFlag = 1'b0;
        bus.Target     = '0;
    endtask

    // Next-state rules of the program counter expressed with plain integers.
    task automatic model_step();
        logic [D-1:0] raw;
        int t;
        raw = bus.Target;
        t = int'(raw);
        if (t >= MODV / 2) t = t - MODV;
        if (Reset) begin
            m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        end else if (m_st == M_RUN) begin
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (bus.Stall) begin
            end else if (bus.Halt) begin
                m_st = M_DONE;
            end else if (bus.BranchEn && bus.BranchFlag) begin
                m_pc = ((m_pc + t) % MODV + MODV) % MODV;
            end else begin
                m_pc = (m_pc + 1) % MODV;
            end
        end else if (bus.Start) begin
            m_pc = int'(bus.StartAddr);
            m_st = M_RUN;
            m_cnt = 0;
        end
    endtask

    task automatic tick();
        int exp_cnt;
        @(posedge Clk);
        model_step();
        #1;
`ifdef PC_CYCLE_COUNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        check("ProgCtr", 32'(bus.ProgCtr), 32'(m_pc));
        check("Running", 32'(bus.Running), 32'(m_st == M_RUN));
        check("Done", 32'(bus.Done), 32'(m_st == M_DONE));
        check("CycleCount", 32'(bus.CycleCount), 32'(exp_cnt));
    endtask

    task automatic restart(input logic [D-1:0] addr);
        clear_inputs();
        bus.Halt = 1'b1;
        tick();
        clear_inputs();
        bus.Start = 1'b1;
        bus.StartAddr = addr;
        tick();
        clear_inputs();
    endtask

    initial begin
        m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        Reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("reset_pc", 32'(bus.ProgCtr), 32'h0);
        check("reset_running", 32'(bus.Running), 32'h0);
        check("reset_done", 32'(bus.Done), 32'h0);
        Reset = 1'b0;

        bus.Start = 1'b1; bus.StartAddr = 12'h100;
        tick();
        check("start_pc", 32'(bus.ProgCtr), 32'h100);
        check("start_running", 32'(bus.Running), 32'h1);
        clear_inputs();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_pc", 32'(bus.ProgCtr), 32'h100 + 32'(i));
        end

        restart(12'h100);
        bus.BranchEn = 1'b1; bus.BranchFlag = 1'b1; bus.Target = 12'hF9B;
        tick();
        check("branch_back", 32'(bus.ProgCtr), 32'h09B);

        restart(12'h100);
        bus.BranchEn = 1'b1; bus.BranchFlag = 1'b0; bus.Target = 12'hF9B;
        tick();
        check("branch_not_taken", 32'(bus.ProgCtr), 32'h101);

        restart(12'h010);
        bus.BranchEn = 1'b1; bus.BranchFlag = 1'b1; bus.Target = 12'h009;
        tick();
        check("branch_fwd", 32'(bus.ProgCtr), 32'h019);

        restart(12'hFFF);
        tick();
        check("wrap", 32'(bus.ProgCtr), 32'h000);

        restart(12'h300);
        bus.BranchEn = 1'b1; bus.BranchFlag = 1'b1; bus.Target = 12'h000;
        tick();
        check("branch_zero", 32'(bus.ProgCtr), 32'h300);

        restart(12'h050);
        bus.Stall = 1'b1; bus.Halt = 1'b1;
        bus.BranchEn = 1'b1; bus.BranchFlag = 1'b1; bus.Target = 12'h005;
        tick();
        tick();
        check("stall_pc", 32'(bus.ProgCtr), 32'h050);
        check("stall_running", 32'(bus.Running), 32'h1);

        restart(12'h020);
        bus.Halt = 1'b1;
        tick();
        check("halt_done", 32'(bus.Done), 32'h1);
        check("halt_pc", 32'(bus.ProgCtr), 32'h020);
        clear_inputs();
        bus.Start = 1'b1; bus.StartAddr = 12'h200;
        tick();
        check("restart_pc", 32'(bus.ProgCtr), 32'h200);
        check("restart_cnt", 32'(bus.CycleCount), 32'h0);

        clear_inputs();
        tick();
        Reset = 1'b1; bus.Start = 1'b1; bus.Halt = 1'b1;
        tick();
        check("reset_wins_pc", 32'(bus.ProgCtr), 32'h0);
        check("reset_wins_running", 32'(bus.Running), 32'h0);
        Reset = 1'b0;
        clear_inputs();
        tick();

        for (int n = 0; n < 3000; n++) begin
            Reset          = ($urandom_range(0, 99) == 0);
            bus.Start      = ($urandom_range(0, 7) == 0);
            bus.StartAddr  = ($urandom_range(0, 3) == 0) ? 12'hFFE : D'($urandom_range(0, MODV - 1));
            bus.Stall      = ($urandom_range(0, 5) == 0);
            bus.Halt       = ($urandom_range(0, 59) == 0);
            bus.BranchEn   = ($urandom_range(0, 2) == 0);
            bus.BranchFlag = $urandom_range(0, 1) == 1;
            bus.Target     = D'($urandom_range(0, MODV - 1));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
